// File: rtl/jpeg_spi_to_buffer.sv
// jpeg_spi_to_buffer
//   Receives a size-prefixed JPEG byte stream from an SPI slave and writes it
//   into a linear byte buffer. The stream consists of a 4-byte big-endian size,
//   then HEADER_SIZE header bytes, then jpeg_size data bytes ending in FF D9.
//   The header and data bytes are written to the buffer. The size bytes are not.
//   Image height and width are picked out of the header as it passes.
//
// Optional feature: define JPEG_RX_SOI_CHECK_EN to require that header bytes 0
//   and 1 are FF D8. A mismatch sends the block to ERR after the offending byte
//   has been written.
//
// Ports
//   clk, reset            : single clock; synchronous active-high reset
//   spi_wr, spi_data      : one-cycle strobe with the received byte
//   rx_clr                : leave DONE/ERR (or abort) and return to IDLE
//   wr_en/wr_addr/wr_data : buffer write port, one cycle after spi_wr
//   jpeg_size             : received size field
//   img_height, img_width : parsed from the header
//   rx_busy/rx_done/rx_err: registered status flags, decoded from the state
module jpeg_spi_to_buffer #(
  parameter int ASZ         = 17,
  parameter int HEADER_SIZE = 607,
  parameter int H_MSB_ADDR  = 159,
  parameter int H_LSB_ADDR  = 160,
  parameter int W_MSB_ADDR  = 161,
  parameter int W_LSB_ADDR  = 162
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           spi_wr,
  input  logic [7:0]     spi_data,
  input  logic           rx_clr,
  output logic           wr_en,
  output logic [ASZ-1:0] wr_addr,
  output logic [7:0]     wr_data,
  output logic [31:0]    jpeg_size,
  output logic [15:0]    img_height,
  output logic [15:0]    img_width,
  output logic           rx_busy,
  output logic           rx_done,
  output logic           rx_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SIZE = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]     state_q, state_d;
  logic [1:0]     size_cnt_q, size_cnt_d;
  // This counter indexes header bytes in HDR and counts data bytes in DATA.
  logic [31:0]    cnt_q, cnt_d;
  // The counter has one extra bit. The top bit is set once the last buffer
  // address has been written, and any further write is an overflow.
  logic [ASZ:0]   next_addr_q, next_addr_d;
  logic [15:0]    tail_q, tail_d;
  logic           wr_en_q, wr_en_d;
  logic [ASZ-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic [31:0]    jpeg_size_q, jpeg_size_d;
  logic [15:0]    img_height_q, img_height_d;
  logic [15:0]    img_width_q, img_width_d;
  logic           rx_busy_q, rx_busy_d;
  logic           rx_done_q, rx_done_d;
  logic           rx_err_q, rx_err_d;

  always_comb begin
    state_d      = state_q;
    size_cnt_d   = size_cnt_q;
    cnt_d        = cnt_q;
    next_addr_d  = next_addr_q;
    tail_d       = tail_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    jpeg_size_d  = jpeg_size_q;
    img_height_d = img_height_q;
    img_width_d  = img_width_q;

    if (rx_clr) begin
      // A concurrent spi_wr is deliberately dropped here.
      state_d     = S_IDLE;
      size_cnt_d  = '0;
      cnt_d       = '0;
      next_addr_d = '0;
      wr_addr_d   = '0;
      tail_d      = '0;
    end else if (spi_wr) begin
      case (state_q)
        S_IDLE: begin
          jpeg_size_d[31:24] = spi_data;
          size_cnt_d         = '0;
          next_addr_d        = '0;
          state_d            = S_SIZE;
        end
        S_SIZE: begin
          case (size_cnt_q)
            2'd0:    jpeg_size_d[23:16] = spi_data;
            2'd1:    jpeg_size_d[15:8]  = spi_data;
            default: jpeg_size_d[7:0]   = spi_data;
          endcase
          size_cnt_d = size_cnt_q + 2'd1;
          if (size_cnt_q == 2'd2) begin
            cnt_d   = '0;
            state_d = S_HDR;
          end
        end
        S_HDR, S_DATA: begin
          if (next_addr_q[ASZ]) begin
            state_d = S_ERR;
          end else begin
            wr_en_d     = 1'b1;
            wr_addr_d   = next_addr_q[ASZ-1:0];
            wr_data_d   = spi_data;
            next_addr_d = next_addr_q + (ASZ+1)'(1);
            if (state_q == S_HDR) begin
              if (cnt_q == 32'(H_MSB_ADDR)) img_height_d[15:8] = spi_data;
              if (cnt_q == 32'(H_LSB_ADDR)) img_height_d[7:0]  = spi_data;
              if (cnt_q == 32'(W_MSB_ADDR)) img_width_d[15:8]  = spi_data;
              if (cnt_q == 32'(W_LSB_ADDR)) img_width_d[7:0]   = spi_data;
              if (cnt_q == 32'(HEADER_SIZE - 1)) begin
                cnt_d   = '0;
                tail_d  = '0;
                state_d = (jpeg_size_q == 32'd0) ? S_ERR : S_DATA;
              end else begin
                cnt_d = cnt_q + 32'd1;
              end
`ifdef JPEG_RX_SOI_CHECK_EN
              if ((cnt_q == 32'd0 && spi_data != 8'hFF) ||
                  (cnt_q == 32'd1 && spi_data != 8'hD8))
                state_d = S_ERR;
`endif
            end else begin
              cnt_d  = cnt_q + 32'd1;
              tail_d = {tail_q[7:0], spi_data};
              // An EOI marker only completes the frame when it lands exactly
              // on the last byte announced by the size field.
              if (tail_q[7:0] == 8'hFF && spi_data == 8'hD9)
                state_d = (cnt_d == jpeg_size_q) ? S_DONE : S_ERR;
              else if (cnt_d == jpeg_size_q)
                state_d = S_ERR;
            end
          end
        end
        default: ;
      endcase
    end

    rx_busy_d = (state_d == S_SIZE) || (state_d == S_HDR) || (state_d == S_DATA);
    rx_done_d = (state_d == S_DONE);
    rx_err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      size_cnt_q   <= '0;
      cnt_q        <= '0;
      next_addr_q  <= '0;
      tail_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      jpeg_size_q  <= '0;
      img_height_q <= '0;
      img_width_q  <= '0;
      rx_busy_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_cnt_q   <= size_cnt_d;
      cnt_q        <= cnt_d;
      next_addr_q  <= next_addr_d;
      tail_q       <= tail_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      jpeg_size_q  <= jpeg_size_d;
      img_height_q <= img_height_d;
      img_width_q  <= img_width_d;
      rx_busy_q    <= rx_busy_d;
      rx_done_q    <= rx_done_d;
      rx_err_q     <= rx_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign jpeg_size  = jpeg_size_q;
  assign img_height = img_height_q;
  assign img_width  = img_width_q;
  assign rx_busy    = rx_busy_q;
  assign rx_done    = rx_done_q;
  assign rx_err     = rx_err_q;

endmodule

// File: tb/tb_jpeg_spi_to_buffer.sv
// Directed bench for jpeg_spi_to_buffer. A frame-level model turns each byte
// stream into an expected list of buffer writes and a final status. A compare
// process pops that list on every write the DUT makes.
module tb_jpeg_spi_to_buffer;
  localparam int ASZ = 17;
  localparam int HS  = 607;

  logic clk = 1'b0, reset = 1'b1, spi_wr = 1'b0, rx_clr = 1'b0;
  logic [7:0] spi_data = '0;
  logic wr_en, rx_busy, rx_done, rx_err;
  logic [ASZ-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [31:0] jpeg_size;
  logic [15:0] img_height, img_width;

  // Small-buffer instance (512 bytes) used to exercise address overflow.
  logic wr_en2, rx_busy2, rx_done2, rx_err2;
  logic [8:0] wr_addr2;
  logic [7:0] wr_data2;
  logic [31:0] jpeg_size2;
  logic [15:0] img_height2, img_width2;

  always #5 clk = ~clk;

  jpeg_spi_to_buffer #(.ASZ(ASZ), .HEADER_SIZE(HS)) dut (
    .clk(clk), .reset(reset), .spi_wr(spi_wr), .spi_data(spi_data), .rx_clr(rx_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .jpeg_size(jpeg_size),
    .img_height(img_height), .img_width(img_width),
    .rx_busy(rx_busy), .rx_done(rx_done), .rx_err(rx_err));

  jpeg_spi_to_buffer #(.ASZ(9), .HEADER_SIZE(HS)) dut2 (
    .clk(clk), .reset(reset), .spi_wr(spi_wr), .spi_data(spi_data), .rx_clr(rx_clr),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .jpeg_size(jpeg_size2),
    .img_height(img_height2), .img_width(img_width2),
    .rx_busy(rx_busy2), .rx_done(rx_done2), .rx_err(rx_err2));

  int n_chk = 0, n_fail = 0;
  int tot_wr = 0;
  int wr2_cnt = 0;
  int wr2_last = -1;

  logic [7:0] fq[$];
  int unsigned exp_a[$];
  logic [7:0] exp_d[$];
  int exp_st;
  int m_writes, m_last;
  logic [31:0] exp_sz;
  logic [15:0] exp_h, exp_w;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // This process checks every buffer write against the model's list.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      tot_wr++;
      if (exp_a.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        check("wr_addr", 64'(wr_addr), 64'(exp_a.pop_front()));
        check("wr_data", 64'(wr_data), 64'(exp_d.pop_front()));
      end
    end
    if (!reset && wr_en2) begin
      wr2_cnt++;
      wr2_last = int'(wr_addr2);
    end
  end

  // Build a frame: size bytes, then a header with SOI (FF, b1) and
  // 200x320 at offsets 159..162, then data with FF D9 ending at data
  // positions e1 and e2 (1-based; 0 means none).
  task automatic build(input int unsigned size, input logic [7:0] b1, input int e1, input int e2);
    logic [31:0] s;
    logic [7:0] b;
    s = size;
    fq.delete();
    fq.push_back(s[31:24]); fq.push_back(s[23:16]); fq.push_back(s[15:8]); fq.push_back(s[7:0]);
    for (int h = 0; h < HS; h++) begin
      b = 8'h11;
      if (h == 0) b = 8'hFF;
      if (h == 1) b = b1;
      if (h == 159) b = 8'h00;
      if (h == 160) b = 8'hC8;
      if (h == 161) b = 8'h01;
      if (h == 162) b = 8'h40;
      fq.push_back(b);
    end
    for (int k = 1; k <= int'(size); k++) begin
      b = 8'h20 + 8'(k % 64);
      if ((e1 > 0 && k == e1 - 1) || (e2 > 0 && k == e2 - 1)) b = 8'hFF;
      if ((e1 > 0 && k == e1) || (e2 > 0 && k == e2)) b = 8'hD9;
      fq.push_back(b);
    end
  endtask

  // Frame-level model of the first n stream bytes. exp_st is 0 for busy,
  // 1 for done and 2 for err.
  task automatic run_model(input int n);
    int unsigned addr, d;
    logic [7:0] b, prev;
    exp_sz = {fq[0], fq[1], fq[2], fq[3]};
    exp_st = 0; addr = 0; d = 0; prev = 8'h00; m_writes = 0; m_last = -1;
    for (int i = 4; i < n && exp_st == 0; i++) begin
      b = fq[i];
      if (addr >= (1 << ASZ)) begin exp_st = 2; break; end
      exp_a.push_back(addr); exp_d.push_back(b);
      m_last = int'(addr); addr++; m_writes++;
      if (i - 4 < HS) begin
        if (i - 4 == 159) exp_h[15:8] = b;
        if (i - 4 == 160) exp_h[7:0]  = b;
        if (i - 4 == 161) exp_w[15:8] = b;
        if (i - 4 == 162) exp_w[7:0]  = b;
        if (i - 4 == HS - 1 && exp_sz == 0) exp_st = 2;
`ifdef JPEG_RX_SOI_CHECK_EN
        if ((i == 4 && b != 8'hFF) || (i == 5 && b != 8'hD8)) exp_st = 2;
`endif
      end else begin
        d++;
        if (prev == 8'hFF && b == 8'hD9) exp_st = (d == exp_sz) ? 1 : 2;
        else if (d == exp_sz) exp_st = 2;
        prev = b;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    spi_data = b; spi_wr = 1'b1;
    @(posedge clk); #1;
    spi_wr = 1'b0;
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic run_frame(input string tag, input int n);
    run_model(n);
    for (int i = 0; i < n; i++) send(fq[i]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_pending"}, 64'(exp_a.size()), 0);
    check({tag, "_done"}, 64'(rx_done), 64'(exp_st == 1));
    check({tag, "_err"}, 64'(rx_err), 64'(exp_st == 2));
    check({tag, "_busy"}, 64'(rx_busy), 64'(exp_st == 0));
    check({tag, "_size"}, 64'(jpeg_size), 64'(exp_sz));
    check({tag, "_h"}, 64'(img_height), 64'(exp_h));
    check({tag, "_w"}, 64'(img_width), 64'(exp_w));
    #1;
  endtask

  task automatic clear();
    rx_clr = 1'b1; @(posedge clk); #1; rx_clr = 1'b0;
    @(negedge clk);
    check("clr_flags", 64'({rx_busy, rx_done, rx_err}), 0);
    #1;
  endtask

  int w0;

  initial begin
    exp_h = '0; exp_w = '0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 0);
    check("rst_wr_addr", 64'(wr_addr), 0);
    check("rst_wr_data", 64'(wr_data), 0);
    check("rst_size", 64'(jpeg_size), 0);
    check("rst_dims", 64'({img_height, img_width}), 0);
    check("rst_flags", 64'({rx_busy, rx_done, rx_err}), 0);
    #1;

    // Nominal 300-byte frame.
    build(300, 8'hD8, 300, 0);
    w0 = tot_wr;
    run_frame("frameA", fq.size());
    check("A_model_writes", 64'(m_writes), 907);
    check("A_model_last", 64'(m_last), 906);
    check("A_dut_writes", 64'(tot_wr - w0), 907);
    check("A_done_lit", 64'(rx_done), 1);
    check("A_h_lit", 64'(img_height), 200);
    check("A_w_lit", 64'(img_width), 320);
    // The 512-byte buffer overflows partway through the header.
    check("ovf_writes", 64'(wr2_cnt), 512);
    check("ovf_last", 64'(wr2_last), 511);
    check("ovf_err", 64'(rx_err2), 1);

    // rx_clr together with spi_wr in DONE: the byte is dropped and the size is kept.
    spi_data = 8'h55; spi_wr = 1'b1; rx_clr = 1'b1;
    @(posedge clk); #1; spi_wr = 1'b0; rx_clr = 1'b0;
    @(negedge clk);
    check("clr_wr_flags", 64'({rx_busy, rx_done, rx_err}), 0);
    check("clr_wr_size", 64'(jpeg_size), 300);
    #1;

    // An early EOI at data byte 150 is an error.
    build(300, 8'hD8, 150, 300);
    run_frame("frameB", fq.size());
    check("B_model_last", 64'(m_last), 756);
    check("B_err_lit", 64'(rx_err), 1);
    clear();

    // 16 data bytes with no EOI.
    build(16, 8'hD8, 0, 0);
    run_frame("frameC", fq.size());
    check("C_model_writes", 64'(m_writes), 623);
    check("C_err_lit", 64'(rx_err), 1);
    clear();

    // A bad SOI byte.
    build(300, 8'hD9, 300, 0);
    run_frame("frameD", fq.size());
`ifdef JPEG_RX_SOI_CHECK_EN
    check("D_err_lit", 64'(rx_err), 1);
`else
    check("D_done_lit", 64'(rx_done), 1);
`endif
    clear();

    // A zero size field.
    build(0, 8'hD8, 0, 0);
    run_frame("frameE", fq.size());
    check("E_err_lit", 64'(rx_err), 1);
    check("E_model_writes", 64'(m_writes), 607);
    clear();

    // The minimum frame: two data bytes, FF D9.
    build(2, 8'hD8, 2, 0);
    run_frame("frameF", fq.size());
    check("F_done_lit", 64'(rx_done), 1);
    clear();

    // Reset after 50 data bytes, then a full frame.
    build(300, 8'hD8, 300, 0);
    run_frame("frameG0", 4 + HS + 50);
    spi_data = 8'hAA; spi_wr = 1'b1; reset = 1'b1;
    @(posedge clk); #1; spi_wr = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("midrst_wr_en", 64'(wr_en), 0);
    check("midrst_addr", 64'(wr_addr), 0);
    check("midrst_size", 64'(jpeg_size), 0);
    check("midrst_dims", 64'({img_height, img_width}), 0);
    check("midrst_flags", 64'({rx_busy, rx_done, rx_err}), 0);
    #1;
    exp_h = '0; exp_w = '0;
    run_frame("frameG", fq.size());
    check("G_done_lit", 64'(rx_done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jpeg_spi_to_buffer.md
JPEG_SPI_TO_BUFFER -- requirements
Module: jpeg_spi_to_buffer

Interface
REQ-001 SHALL have parameter ASZ, default 17, the buffer address width in bits.
REQ-002 SHALL have parameter HEADER_SIZE, default 607, the number of JFIF header bytes that follow the size field.
REQ-003 SHALL have parameters H_MSB_ADDR, H_LSB_ADDR, W_MSB_ADDR and W_LSB_ADDR, defaults 159, 160, 161 and 162, the header byte offsets of height MSB/LSB and width MSB/LSB.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port spi_wr, input, 1 bit: single-cycle strobe marking one received stream byte.
REQ-007 SHALL have port spi_data, input, 8 bits: the byte, valid while spi_wr=1.
REQ-008 SHALL have port rx_clr, input, 1 bit: clears DONE or ERR and returns to IDLE.
REQ-009 SHALL have port wr_en, output, 1 bit: buffer write strobe.
REQ-010 SHALL have port wr_addr, output, ASZ bits: buffer write address.
REQ-011 SHALL have port wr_data, output, 8 bits: buffer write data.
REQ-012 SHALL have port jpeg_size, output, 32 bits: the received size field.
REQ-013 SHALL have ports img_height and img_width, outputs, 16 bits each: parsed from the header.
REQ-014 SHALL have ports rx_busy, rx_done and rx_err, outputs, 1 bit each: status flags.

Function
REQ-015 Stream format SHALL be: 4 size bytes (big-endian), then HEADER_SIZE header bytes, then jpeg_size data bytes, the last two of which are FF D9.
REQ-016 FSM states SHALL be IDLE, SIZE, HDR, DATA, DONE and ERR.
REQ-017 In IDLE, a spi_wr SHALL load the byte into jpeg_size[31:24] and move the FSM to SIZE.
REQ-018 In SIZE, the next 3 strobes SHALL fill jpeg_size[23:16], [15:8] and [7:0]; after the 3rd the FSM SHALL go to HDR.
REQ-019 In HDR and DATA, each strobe SHALL assert wr_en for exactly one cycle, on the cycle after spi_wr.
- wr_data = the byte.
- wr_addr starts at 0 for the first header byte and increments by 1 after each write.
- Size bytes are never written.
REQ-020 In HDR, the bytes at offsets H_MSB_ADDR..W_LSB_ADDR SHALL be latched into img_height[15:8], img_height[7:0], img_width[15:8] and img_width[7:0] respectively.
REQ-021 After HEADER_SIZE header bytes the FSM SHALL enter DATA with the data byte counter = 0.
REQ-022 In DATA, the block SHALL keep a 16-bit shift register of the last two bytes; FF D9 is detected on arrival of the D9.
REQ-023 On EOI, if the data counter (including the D9) equals jpeg_size, the FSM SHALL go to DONE; otherwise it SHALL go to ERR.
REQ-024 If the data counter reaches jpeg_size with no EOI detected, the FSM SHALL go to ERR.
REQ-025 Address overflow SHALL be an error: a write with wr_addr = 2^ASZ-1 already used SHALL move the FSM to ERR, and no wrap write occurs.
REQ-026 jpeg_size = 0 SHALL cause ERR on entry to DATA.
REQ-027 The flags SHALL be decoded from state:
- rx_busy = 1 in SIZE, HDR and DATA.
- rx_done = 1 in DONE.
- rx_err = 1 in ERR.
- All three are registered.
REQ-028 In DONE and ERR, spi_wr SHALL be ignored and wr_en SHALL stay 0.
REQ-029 rx_clr SHALL return the FSM to IDLE from any state next cycle. It clears the counters and wr_addr; jpeg_size, img_height and img_width hold their values. rx_clr has priority over a simultaneous spi_wr, whose byte is dropped.
REQ-030 Back-to-back spi_wr on consecutive cycles SHALL be accepted without loss.

Reset
REQ-031 When reset=1 at a clock edge, all state SHALL be cleared:
- FSM = IDLE.
- wr_en = 0, wr_addr = 0, wr_data = 0.
- jpeg_size = 0, img_height = 0, img_width = 0.
- All flags = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; no write occurs on the reset cycle.

Configuration
REQ-033 Macro JPEG_RX_SOI_CHECK_EN controls the SOI check.
- Defined: header bytes 0 and 1 must be FF and D8; a mismatch moves the FSM to ERR after the offending byte, and that byte is still written.
- Undefined: no SOI check; the header is accepted as-is.

Verification
REQ-034 Frame: size 00 00 01 2C, 607-byte header with FF D8 and offsets 159..162 = 00 C8 01 40, then 300 data bytes ending FF D9 -> 907 writes at addresses 0..906, img_height=200, img_width=320, rx_done=1.
REQ-035 Same frame with FF D9 at data byte 150 -> rx_err=1, and no writes after address 756.
REQ-036 Size 0x10 with 16 data bytes and no FF D9 -> rx_err=1 after the 16th data byte.
REQ-037 reset pulsed at data byte 50, then a full frame -> the second frame is written from address 0 and completes with rx_done=1.
REQ-038 With JPEG_RX_SOI_CHECK_EN defined, header byte 1 = 0xD9 -> rx_err=1; undefined, the same stream -> rx_done=1.
REQ-039 rx_clr in DONE concurrent with spi_wr -> IDLE, the byte is ignored, and jpeg_size is retained.
